axi4_lite_master: RTL

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axil_pkg.sv | 26 ++
 rtl/axi4_lite_master_if.sv | 40 ++++
 rtl/axil_watchdog.sv | 31 +++
 rtl/axi4_lite_master.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite master: response codes and FSM encoding.
// Build option: AXIL_MASTER_TIMEOUT_EN adds the watchdog.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_e;

    function automatic logic busy_state(state_e s);
        return (s == WRITE) || (s == WRESP) ||
               (s == RADDR) || (s == RDATA);
    endfunction

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
// Build option: AXIL_MASTER_TIMEOUT_EN (no effect here).
interface axi4_lite_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID,
        output BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID,
        input  ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID,
        input  BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID,
        output ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_watchdog.sv
// Busy-state cycle counter with a sticky timeout flag.
// Only instantiated when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_watchdog #(
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic busy,
    input  logic clr,
    output logic timeout
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            if (clr || !busy)
                cnt_q <= '0;
            else if (cnt_q != LIM)
                cnt_q <= cnt_q + 1'b1;
            // flag on the edge the count reaches the limit
            if (busy && !clr && cnt_q == LIM - 1'b1)
                timeout <= 1'b1;
        end
    end
endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master driven by a cmd/rsp handshake.
// Build option: AXIL_MASTER_TIMEOUT_EN enables the axil_watchdog flag.
module axi4_lite_master
    import axil_pkg::*;
#(
    parameter  int ADDR_W         = 8,
    parameter  int DATA_W         = 8,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int STRB_W         = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    axi4_lite_master_if.master m_axi,
    output logic              timeout
);
    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;
    logic aw_done, w_done;
    logic aw_v, w_v, b_r, ar_v, r_r;
    logic accept, aw_hs, w_hs;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        aw_v      = 1'b0;
        w_v       = 1'b0;
        b_r       = 1'b0;
        ar_v      = 1'b0;
        r_r       = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = ARESETN;
                if (cmd_valid && ARESETN)
                    state_d = cmd_write ? WRITE : RADDR;
            end
            WRITE: begin
                // AW and W retire independently
                aw_v  = !aw_done;
                w_v   = !w_done;
                aw_hs = aw_v && m_axi.AWREADY;
                w_hs  = w_v && m_axi.WREADY;
                if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_d = WRESP;
            end
            WRESP: begin
                b_r = 1'b1;
                if (m_axi.BVALID) state_d = RESP;
            end
            RADDR: begin
                ar_v = 1'b1;
                if (m_axi.ARREADY) state_d = RDATA;
            end
            RDATA: begin
                r_r = 1'b1;
                if (m_axi.RVALID) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (state_q == WRESP && m_axi.BVALID) begin
                resp_q  <= m_axi.BRESP;
                rdata_q <= '0;
            end
            if (state_q == RDATA && m_axi.RVALID) begin
                resp_q  <= m_axi.RRESP;
                rdata_q <= m_axi.RDATA;
            end
        end
    end

    assign m_axi.AWADDR  = addr_q;
    assign m_axi.ARADDR  = addr_q;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.WSTRB   = wstrb_q;
    assign m_axi.AWVALID = aw_v;
    assign m_axi.WVALID  = w_v;
    assign m_axi.BREADY  = b_r;
    assign m_axi.ARVALID = ar_v;
    assign m_axi.RREADY  = r_r;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
    axil_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .busy   (busy_state(state_q)),
        .clr    (state_d != state_q),
        .timeout(timeout)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif
endmodule
